// File: rtl/phase_gen.sv
// Phase accumulator with NCH offset-shifted outputs. It free-runs in CONT mode,
// or runs one accumulator revolution per start pulse in ONESHOT mode.
module phase_gen #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [WIDTH-1:0]         incr,
  input  logic                     mode,
  input  logic                     start,
  input  logic                     wr_en,
  input  logic [$clog2(NCH)-1:0]   wr_ch,
  input  logic [WIDTH-1:0]         wr_offset,
  output logic [NCH*WIDTH-1:0]     count,
  output logic                     wrap,
  output logic                     busy,
  output logic                     done
);
  localparam int CW = $clog2(NCH);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] off [NCH];
  logic [WIDTH:0]   sum;
  logic             step;
  logic             launch;

  function automatic logic [WIDTH-1:0] phase_add(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
    return a + b;
  endfunction

  assign sum    = {1'b0, acc} + {1'b0, incr};
  assign step   = en && (!mode || state == RUN);
  assign launch = (state == IDLE) && mode && start;
  assign busy   = (state == RUN);

  // Single register stage: accumulator, channel outputs, offsets and FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      count <= '0;
      wrap  <= 1'b0;
      done  <= 1'b0;
      for (int i = 0; i < NCH; i++) off[i] <= '0;
    end else begin
      wrap <= 1'b0;
      done <= 1'b0;
      // An index that matches no channel leaves every offset untouched
      for (int i = 0; i < NCH; i++)
        if (wr_en && wr_ch == CW'(i)) off[i] <= wr_offset;

      if (launch) begin
        // A launch publishes the offsets as seen after a same-cycle write
        state <= RUN;
        acc   <= '0;
        for (int i = 0; i < NCH; i++)
          count[i*WIDTH +: WIDTH] <= (wr_en && wr_ch == CW'(i)) ? wr_offset : off[i];
      end else begin
        if (step) begin
          acc  <= sum[WIDTH-1:0];
          wrap <= sum[WIDTH];
          for (int i = 0; i < NCH; i++)
            count[i*WIDTH +: WIDTH] <= phase_add(sum[WIDTH-1:0], off[i]);
        end
        if (state == RUN) begin
          if (!mode) begin
            state <= IDLE;
          end else if (step && sum[WIDTH]) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_phase_gen.sv
// Bench for phase_gen: directed scenarios plus randomized traffic compared
// against a cycle-level behavioural model of phase accumulation.
module tb_phase_gen;
  localparam int W = 8;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           en = 1'b0;
  logic [W-1:0]   incr = '0;
  logic           mode = 1'b0;
  logic           start = 1'b0;
  logic           wr_en = 1'b0;
  logic [1:0]     wr_ch = '0;
  logic [W-1:0]   wr_offset = '0;
  logic [N*W-1:0] count;
  logic           wrap, busy, done;

  int ntests = 0;
  int nfail  = 0;

  // Behavioural model state
  int m_acc;
  int m_off [N];
  int m_cnt [N];
  bit m_run, m_wrap, m_done;

  phase_gen #(.WIDTH(W), .NCH(N)) dut (
    .clk(clk), .rst(rst), .en(en), .incr(incr), .mode(mode), .start(start),
    .wr_en(wr_en), .wr_ch(wr_ch), .wr_offset(wr_offset),
    .count(count), .wrap(wrap), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [N*W-1:0] mcount();
    logic [N*W-1:0] v;
    for (int i = 0; i < N; i++) v[i*W +: W] = W'(m_cnt[i]);
    return v;
  endfunction

  function automatic int ch(input logic [N*W-1:0] c, input int i);
    return int'(c[i*W +: W]);
  endfunction

  task automatic model_reset();
    m_acc = 0; m_run = 0; m_wrap = 0; m_done = 0;
    for (int i = 0; i < N; i++) begin m_off[i] = 0; m_cnt[i] = 0; end
  endtask

  // Advance the model by one clock using the inputs as they stand at the edge
  task automatic model_edge();
    bit st, carry;
    int s;
    if (rst) begin model_reset(); return; end
    m_wrap = 0; m_done = 0;
    if (!m_run && mode && start) begin
      if (wr_en) m_off[wr_ch] = wr_offset;
      m_run = 1; m_acc = 0;
      for (int i = 0; i < N; i++) m_cnt[i] = m_off[i];
    end else begin
      st = en && (!mode || m_run);
      carry = 0;
      if (st) begin
        s = m_acc + int'(incr);
        carry = (s >= 256);
        m_acc = s % 256;
        m_wrap = carry;
        for (int i = 0; i < N; i++) m_cnt[i] = (m_acc + m_off[i]) % 256;
      end
      if (m_run) begin
        if (!mode) m_run = 0;
        else if (st && carry) begin m_run = 0; m_done = 1; end
      end
      if (wr_en) m_off[wr_ch] = wr_offset;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    en = 0; incr = '0; mode = 0; start = 0; wr_en = 0; wr_ch = '0; wr_offset = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    ntests++;
    if (count !== '0 || wrap !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      nfail++;
      $display("FAIL reset_state: count=%h wrap=%b busy=%b done=%b, required all 0",
               count, wrap, busy, done);
    end
  endtask

  task automatic test_cont_offsets();
    int offs [N];
    offs = '{0, 64, 128, 192};
    do_reset();
    for (int i = 0; i < N; i++) begin
      wr_en = 1; wr_ch = 2'(i); wr_offset = W'(offs[i]);
      tick();
    end
    wr_en = 0; en = 1; incr = 8'd1;
    tick();
    ntests++;
    if (count !== 32'hC1_81_41_01) begin
      nfail++;
      $display("FAIL cont_first_step: count=%h required=%h", count, 32'hC1_81_41_01);
    end
    for (int k = 2; k <= 256; k++) begin
      tick();
      ntests++;
      if (wrap !== (k == 256) || ch(count, 0) != (k % 256)) begin
        nfail++;
        $display("FAIL cont_ramp step %0d: count0=%0d wrap=%b required count0=%0d wrap=%b",
                 k, ch(count, 0), wrap, k % 256, k == 256);
      end
    end
  endtask

  task automatic test_cont_incr100();
    int exp_c [6];
    bit exp_w [6];
    exp_c = '{100, 200, 44, 144, 244, 88};
    exp_w = '{0, 0, 1, 0, 0, 1};
    do_reset();
    en = 1; incr = 8'd100;
    for (int k = 0; k < 6; k++) begin
      tick();
      ntests++;
      if (ch(count, 0) != exp_c[k] || wrap !== exp_w[k] || busy !== 1'b0 || done !== 1'b0) begin
        nfail++;
        $display("FAIL cont_incr100 step %0d: count0=%0d wrap=%b busy=%b done=%b required %0d %b 0 0",
                 k, ch(count, 0), wrap, busy, done, exp_c[k], exp_w[k]);
      end
    end
  endtask

  task automatic test_oneshot();
    int exp_c [4];
    exp_c = '{64, 128, 192, 0};
    do_reset();
    mode = 1; incr = 8'd64; en = 1; start = 1;
    tick();
    start = 0;
    ntests++;
    if (busy !== 1'b1 || ch(count, 0) != 0 || done !== 1'b0) begin
      nfail++;
      $display("FAIL oneshot_launch: busy=%b count0=%0d done=%b required 1 0 0",
               busy, ch(count, 0), done);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      ntests++;
      if (ch(count, 0) != exp_c[k] || wrap !== (k == 3) || done !== (k == 3) || busy !== (k != 3)) begin
        nfail++;
        $display("FAIL oneshot_rev %0d: count0=%0d wrap=%b done=%b busy=%b required %0d %b %b %b",
                 k, ch(count, 0), wrap, done, busy, exp_c[k], k == 3, k == 3, k != 3);
      end
    end
    for (int k = 0; k < 5; k++) begin
      tick();
      ntests++;
      if (ch(count, 0) != 0 || wrap !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
        nfail++;
        $display("FAIL oneshot_after %0d: count0=%0d wrap=%b done=%b busy=%b required 0 0 0 0",
                 k, ch(count, 0), wrap, done, busy);
      end
    end
  endtask

  task automatic test_write_and_step();
    do_reset();
    en = 1; incr = 8'd5;
    tick();
    incr = 8'd1; wr_en = 1; wr_ch = 2'd1; wr_offset = 8'd10;
    tick();
    ntests++;
    if (ch(count, 1) != 6) begin
      nfail++;
      $display("FAIL write_same_cycle: count1=%0d required=6", ch(count, 1));
    end
    wr_en = 0; en = 0; wr_ch = 2'd2; wr_offset = 8'd99;
    wr_en = 1;
    tick();
    wr_en = 0;
    ntests++;
    if (ch(count, 1) != 6 || ch(count, 2) != 6) begin
      nfail++;
      $display("FAIL write_no_step: count1=%0d count2=%0d required 6 6", ch(count, 1), ch(count, 2));
    end
    en = 1;
    tick();
    ntests++;
    if (ch(count, 1) != 17 || ch(count, 2) != 106) begin
      nfail++;
      $display("FAIL write_next_step: count1=%0d count2=%0d required 17 106",
               ch(count, 1), ch(count, 2));
    end
  endtask

  task automatic test_pause_and_abort();
    logic [N*W-1:0] held;
    do_reset();
    mode = 1; incr = 8'd64; en = 1; start = 1;
    tick();
    start = 0;
    tick();
    held = count;
    en = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      ntests++;
      if (count !== held || busy !== 1'b1 || wrap !== 1'b0 || done !== 1'b0) begin
        nfail++;
        $display("FAIL pause %0d: count=%h busy=%b wrap=%b done=%b required %h 1 0 0",
                 k, count, busy, wrap, done, held);
      end
    end
    en = 1;
    tick();
    ntests++;
    if (ch(count, 0) != 128 || busy !== 1'b1) begin
      nfail++;
      $display("FAIL resume: count0=%0d busy=%b required 128 1", ch(count, 0), busy);
    end
    rst = 1;
    #1;
    model_reset();
    ntests++;
    if (count !== '0 || busy !== 1'b0 || done !== 1'b0 || wrap !== 1'b0) begin
      nfail++;
      $display("FAIL async_reset: count=%h busy=%b done=%b wrap=%b required all 0",
               count, busy, done, wrap);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      ntests++;
      if (done !== 1'b0 || count !== '0) begin
        nfail++;
        $display("FAIL reset_hold %0d: done=%b count=%h required 0 0", k, done, count);
      end
    end
    rst = 0; mode = 0; incr = 8'd3;
    tick();
    ntests++;
    if (ch(count, 0) != 3 || done !== 1'b0) begin
      nfail++;
      $display("FAIL post_reset_step: count0=%0d done=%b required 3 0", ch(count, 0), done);
    end
  endtask

  task automatic test_zero_incr();
    logic [N*W-1:0] held;
    do_reset();
    en = 1; incr = 8'd37;
    tick();
    held = count;
    incr = 8'd0;
    for (int k = 0; k < 300; k++) begin
      tick();
      ntests++;
      if (count !== held || wrap !== 1'b0) begin
        nfail++;
        $display("FAIL zero_incr %0d: count=%h wrap=%b required %h 0", k, count, wrap, held);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 2000; k++) begin
      en        = ($urandom_range(0, 9) < 8);
      mode      = ($urandom_range(0, 9) < 7);
      start     = ($urandom_range(0, 9) < 2);
      incr      = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 255)) : W'($urandom_range(0, 40));
      wr_en     = ($urandom_range(0, 9) < 2);
      wr_ch     = 2'($urandom_range(0, N - 1));
      wr_offset = W'($urandom_range(0, 255));
      tick();
      ntests++;
      if (count !== mcount() || wrap !== m_wrap || busy !== m_run || done !== m_done) begin
        nfail++;
        $display("FAIL random %0d: count=%h wrap=%b busy=%b done=%b required %h %b %b %b",
                 k, count, wrap, busy, done, mcount(), m_wrap, m_run, m_done);
      end
    end
    idle_inputs();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_cont_offsets();
    test_cont_incr100();
    test_oneshot();
    test_write_and_step();
    test_pause_and_abort();
    test_zero_incr();
    test_random();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
